// File: rtl/ni_dec_pkg.sv
`include "global.vh"
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : ni_dec_pkg                                                   |
// | Purpose  : Widths, productive-vector bit names and a popcount helper    |
// |            shared by the DEC network interface and its sub-blocks.      |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
package ni_dec_pkg;

  localparam int W_CORD = `WIDTH_CORD;
  localparam int W_DATA = `WIDTH_DATA;
  localparam int W_PORT = `WIDTH_PORT;
  localparam int W_PV   = `WIDTH_PV;
  localparam int W_XY   = 2 * W_CORD;
  // Injection entries are stored without the valid bit; it is added on the way out.
  localparam int W_INJ  = W_PORT - 1;
  // Ejection entries keep only what the core sees: {src, data}.
  localparam int W_EJ   = W_XY + W_DATA;

  // Bit positions inside a productive vector; same N,E,S,W order as nbr_valid.
  typedef enum logic [1:0] {
    PV_W = 2'd0,
    PV_S = 2'd1,
    PV_E = 2'd2,
    PV_N = 2'd3
  } pv_bit_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/global.vh
// ---------------------------------------------------------------------------
// Shared flit geometry for the DEC router and its network interface.
// Flit layout (MSB..LSB): valid | x_dst | y_dst | x_src | y_src | data
// ---------------------------------------------------------------------------
`ifndef GLOBAL_VH
`define GLOBAL_VH

`define WIDTH_CORD 2
`define WIDTH_DATA 16
`define WIDTH_PORT 25
`define WIDTH_PV   4

`define POS_VALID  24
`define POS_X_DST  23:22
`define POS_Y_DST  21:20
`define POS_X_SRC  19:18
`define POS_Y_SRC  17:16
`define POS_DATA   15:0

`endif

// File: rtl/ni_dec_fifo_sync.sv
`include "global.vh"
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : fifo_sync                                                    |
// | Purpose  : Single-clock FIFO with registered pointers and a             |
// |            combinational head read. Pointers carry one extra wrap bit   |
// |            so full and empty are distinguishable.                       |
// | Ports    : clk, rst_n (async, active-low)                               |
// |            push/din   - write; taken when not full, or when full and    |
// |                         popped in the same cycle                        |
// |            pop        - remove head; ignored when empty                 |
// |            full/empty - status from the registered pointers             |
// |            head       - oldest entry (undefined while empty)            |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is safe when the head leaves on the same edge:
  // the slot being written is the one being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/rc.sv
`include "global.vh"
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : rc                                                           |
// | Purpose  : Minimal-path route computation. Marks every output port that |
// |            moves a flit closer to its destination (x grows east, y      |
// |            grows north). A flit already at its node gets an empty PV.  |
// | Ports    : dst_x, dst_y - destination coordinate                        |
// |            pv           - productive vector {N,E,S,W}                   |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module rc
  import ni_dec_pkg::*;
#(
  parameter int CORD_X = 0,
  parameter int CORD_Y = 0
) (
  input  logic [W_CORD-1:0] dst_x,
  input  logic [W_CORD-1:0] dst_y,
  output logic [W_PV-1:0]   pv
);

  localparam logic [W_CORD-1:0] MY_X = W_CORD'(CORD_X);
  localparam logic [W_CORD-1:0] MY_Y = W_CORD'(CORD_Y);

  always_comb begin
    pv = '0;
    if (dst_y > MY_Y) pv[PV_N] = 1'b1;
    if (dst_x > MY_X) pv[PV_E] = 1'b1;
    if (dst_y < MY_Y) pv[PV_S] = 1'b1;
    if (dst_x < MY_X) pv[PV_W] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/ni_dec.sv
`include "global.vh"
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : ni_dec                                                       |
// | Purpose  : Network interface between a core and the local port of a    |
// |            DEC router node. Queues core packets and injects them when   |
// |            the router has a free slot; absorbs every ejected flit into  |
// |            a FIFO drained by the core. Reports starvation, ejection     |
// |            overflow and traffic counts.                                 |
// | Ports    : clk, reset (async, active-low)                               |
// |            core_tx_*  - core -> NI packet handshake                     |
// |            nbr_valid  - router input occupancy {N,E,S,W}                |
// |            dinLocal / PVLocal - flit and productive vector to router    |
// |            doutLocal  - flit ejected by router (never back-pressured)   |
// |            core_rx_*  - NI -> core packet handshake                     |
// |            starve, eject_overflow, inj_count, ej_count - status         |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module ni_dec
  import ni_dec_pkg::*;
#(
  parameter int CORD_X       = 0,
  parameter int CORD_Y       = 0,
  parameter int INJ_DEPTH    = 4,
  parameter int EJ_DEPTH     = 4,
  parameter int INJ_THRESH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_tx_valid,
  output logic                    core_tx_ready,
  input  logic [2*`WIDTH_CORD-1:0] core_tx_dst,
  input  logic [`WIDTH_DATA-1:0]  core_tx_data,
  input  logic [3:0]              nbr_valid,
  output logic [`WIDTH_PORT-1:0]  dinLocal,
  output logic [`WIDTH_PV-1:0]    PVLocal,
  input  logic [`WIDTH_PORT-1:0]  doutLocal,
  output logic                    core_rx_valid,
  input  logic                    core_rx_ready,
  output logic [2*`WIDTH_CORD-1:0] core_rx_src,
  output logic [`WIDTH_DATA-1:0]  core_rx_data,
  output logic                    starve,
  output logic                    eject_overflow,
  output logic [15:0]             inj_count,
  output logic [15:0]             ej_count
);

  localparam logic [W_CORD-1:0] MY_X = W_CORD'(CORD_X);
  localparam logic [W_CORD-1:0] MY_Y = W_CORD'(CORD_Y);
  localparam int                SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     SLIM = SW'(STARVE_LIMIT);

  // ---------------- injection path ----------------
  logic             inj_full;
  logic             inj_empty;
  logic             tx_push;
  logic             inject_ok;
  logic [W_INJ-1:0] inj_din;
  logic [W_INJ-1:0] inj_head;
  logic [W_PV-1:0]  head_pv;

  assign core_tx_ready = !inj_full;
  assign tx_push       = core_tx_valid && core_tx_ready;
  assign inj_din       = {core_tx_dst, MY_X, MY_Y, core_tx_data};

  fifo_sync #(
    .WIDTH (W_INJ),
    .DEPTH (INJ_DEPTH)
  ) u_inj_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (tx_push),
    .din   (inj_din),
    .pop   (inject_ok),
    .full  (inj_full),
    .empty (inj_empty),
    .head  (inj_head)
  );

  rc #(
    .CORD_X (CORD_X),
    .CORD_Y (CORD_Y)
  ) u_rc (
    .dst_x (inj_head[`POS_X_DST]),
    .dst_y (inj_head[`POS_Y_DST]),
    .pv    (head_pv)
  );

  // Decided in the same cycle from live nbr_valid: the router latches its
  // neighbour flits and dinLocal on the same edge.
  assign inject_ok = !inj_empty && (int'(popcount4(nbr_valid)) < INJ_THRESH);

  always_comb begin
    dinLocal = '0;
    PVLocal  = '0;
    if (inject_ok) begin
      dinLocal = {1'b1, inj_head};
      PVLocal  = head_pv;
    end
  end

  // ---------------- starvation ----------------
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;

  always_comb begin
    starve_nxt = starve_cnt;
    if (inj_empty || inject_ok) begin
      starve_nxt = '0;
    end else if (starve_cnt != SLIM) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
      inj_count  <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      starve     <= (starve_nxt == SLIM);
      if (inject_ok) inj_count <= inj_count + 16'd1;
    end
  end

  // ---------------- ejection path ----------------
  logic            ej_full;
  logic            ej_empty;
  logic            ej_in_valid;
  logic            rx_pop;
  logic            ej_accept;
  logic [W_EJ-1:0] ej_din;
  logic [W_EJ-1:0] ej_head;
  logic            unused_dout_dst;

  assign ej_in_valid = doutLocal[`POS_VALID];
  assign rx_pop      = core_rx_valid && core_rx_ready;
  // A full FIFO can still take the flit if the core drains the head this cycle.
  assign ej_accept   = ej_in_valid && (!ej_full || rx_pop);
  assign ej_din      = {doutLocal[`POS_X_SRC], doutLocal[`POS_Y_SRC], doutLocal[`POS_DATA]};
  // Destination fields of an ejected flit always name this node.
  assign unused_dout_dst = ^{doutLocal[`POS_X_DST], doutLocal[`POS_Y_DST]};

  fifo_sync #(
    .WIDTH (W_EJ),
    .DEPTH (EJ_DEPTH)
  ) u_ej_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (ej_accept),
    .din   (ej_din),
    .pop   (rx_pop),
    .full  (ej_full),
    .empty (ej_empty),
    .head  (ej_head)
  );

  assign core_rx_valid = !ej_empty;
  // Outputs are zeroed while empty so stale storage never leaks to the core.
  assign core_rx_src   = core_rx_valid ? ej_head[W_EJ-1:W_DATA] : '0;
  assign core_rx_data  = core_rx_valid ? ej_head[W_DATA-1:0]    : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eject_overflow <= 1'b0;
      ej_count       <= '0;
    end else begin
      if (ej_in_valid && !ej_accept) eject_overflow <= 1'b1;
      if (ej_accept)                 ej_count       <= ej_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ni_dec.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_ni_dec                                                    |
// | Purpose  : Self-checking bench for ni_dec: directed scenarios plus a    |
// |            random phase, all compared every cycle against a queue-based |
// |            reference model of the interface.                            |
// | Revision : 1.0 - initial release                                        |
// +-------------------------------------------------------------------------+
module tb_ni_dec;
  import ni_dec_pkg::*;

  localparam int CX     = 1;
  localparam int CY     = 2;
  localparam int INJ_D  = 4;
  localparam int EJ_D   = 4;
  localparam int THRESH = 4;
  localparam int SLIMIT = 16;
  localparam logic [1:0] CXB = 2'd1;
  localparam logic [1:0] CYB = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_tx_valid;
  logic        core_tx_ready;
  logic [3:0]  core_tx_dst;
  logic [15:0] core_tx_data;
  logic [3:0]  nbr_valid;
  logic [24:0] dinLocal;
  logic [3:0]  PVLocal;
  logic [24:0] doutLocal;
  logic        core_rx_valid;
  logic        core_rx_ready;
  logic [3:0]  core_rx_src;
  logic [15:0] core_rx_data;
  logic        starve;
  logic        eject_overflow;
  logic [15:0] inj_count;
  logic [15:0] ej_count;

  ni_dec #(
    .CORD_X(CX), .CORD_Y(CY), .INJ_DEPTH(INJ_D), .EJ_DEPTH(EJ_D),
    .INJ_THRESH(THRESH), .STARVE_LIMIT(SLIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .core_tx_dst(core_tx_dst), .core_tx_data(core_tx_data),
    .nbr_valid(nbr_valid), .dinLocal(dinLocal), .PVLocal(PVLocal),
    .doutLocal(doutLocal),
    .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
    .core_rx_src(core_rx_src), .core_rx_data(core_rx_data),
    .starve(starve), .eject_overflow(eject_overflow),
    .inj_count(inj_count), .ej_count(ej_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queues of {dst,data} waiting to inject and {src,data}
  // waiting for the core, plus plain counters.
  logic [19:0] inj_q[$];
  logic [19:0] ej_q[$];
  int          m_inj_cnt;
  int          m_ej_cnt;
  int          m_blocked;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pv_ref(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] p;
    p[3] = (int'(y) > CY);  // north
    p[2] = (int'(x) > CX);  // east
    p[1] = (int'(y) < CY);  // south
    p[0] = (int'(x) < CX);  // west
    return p;
  endfunction

  function automatic logic [24:0] mk_flit(input logic [3:0] src, input logic [15:0] data);
    return {1'b1, CXB, CYB, src, data};
  endfunction

  task automatic model_clear();
    inj_q.delete();
    ej_q.delete();
    m_inj_cnt = 0;
    m_ej_cnt  = 0;
    m_blocked = 0;
    m_ovf     = 1'b0;
  endtask

  // One clock cycle: compare every output at the negedge, advance the model
  // as the coming posedge will, then return just after that posedge.
  task automatic cycle();
    logic [19:0] e;
    logic        inj;
    logic        rdy;
    logic        ej_pop;
    logic        ej_full;
    logic [31:0] exp_din;
    logic [31:0] exp_pv;
    @(negedge clk);
    rdy     = (inj_q.size() < INJ_D);
    inj     = (inj_q.size() != 0) && ($countones(nbr_valid) < THRESH);
    exp_din = 32'd0;
    exp_pv  = 32'd0;
    if (inj) begin
      e       = inj_q[0];
      exp_din = 32'({1'b1, e[19:16], CXB, CYB, e[15:0]});
      exp_pv  = 32'(pv_ref(e[19:18], e[17:16]));
    end
    chk("tx_ready", 32'(core_tx_ready), 32'(rdy));
    chk("dinLocal", 32'(dinLocal), exp_din);
    chk("PVLocal", 32'(PVLocal), exp_pv);
    chk("rx_valid", 32'(core_rx_valid), 32'(ej_q.size() != 0));
    if (ej_q.size() != 0) begin
      chk("rx_src", 32'(core_rx_src), 32'(ej_q[0][19:16]));
      chk("rx_data", 32'(core_rx_data), 32'(ej_q[0][15:0]));
    end
    chk("starve", 32'(starve), 32'(m_blocked == SLIMIT));
    chk("overflow", 32'(eject_overflow), 32'(m_ovf));
    chk("inj_count", 32'(inj_count), 32'(m_inj_cnt & 16'hFFFF));
    chk("ej_count", 32'(ej_count), 32'(m_ej_cnt & 16'hFFFF));

    ej_full = (ej_q.size() == EJ_D);
    ej_pop  = (ej_q.size() != 0) && core_rx_ready;
    if (inj_q.size() == 0 || inj) m_blocked = 0;
    else if (m_blocked < SLIMIT)  m_blocked++;
    if (inj) begin
      void'(inj_q.pop_front());
      m_inj_cnt++;
    end
    if (core_tx_valid && rdy) inj_q.push_back({core_tx_dst, core_tx_data});
    if (ej_pop) void'(ej_q.pop_front());
    if (doutLocal[24]) begin
      if (!ej_full || ej_pop) begin
        ej_q.push_back({doutLocal[19:16], doutLocal[15:0]});
        m_ej_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_tx_ready"}, 32'(core_tx_ready), 32'd1);
    chk({tag, "_dinLocal"}, 32'(dinLocal), 32'd0);
    chk({tag, "_PVLocal"}, 32'(PVLocal), 32'd0);
    chk({tag, "_rx_valid"}, 32'(core_rx_valid), 32'd0);
    chk({tag, "_starve"}, 32'(starve), 32'd0);
    chk({tag, "_overflow"}, 32'(eject_overflow), 32'd0);
    chk({tag, "_inj_count"}, 32'(inj_count), 32'd0);
    chk({tag, "_ej_count"}, 32'(ej_count), 32'd0);
  endtask

  task automatic idle_inputs();
    core_tx_valid = 1'b0;
    core_tx_dst   = '0;
    core_tx_data  = '0;
    nbr_valid     = '0;
    doutLocal     = '0;
    core_rx_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] srcs [3];
    reset = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;

    // Idle inject: dst (2,1) leaves one cycle after it is accepted.
    core_tx_valid = 1'b1;
    core_tx_dst   = {2'd2, 2'd1};
    core_tx_data  = 16'h00A5;
    cycle();
    core_tx_valid = 1'b0;
    cycle();
    chk("tp_idle_inj_count", 32'(inj_count), 32'd1);

    // Blocked head: starve rises after 16 blocked cycles, clears after release.
    nbr_valid     = 4'b1111;
    core_tx_valid = 1'b1;
    core_tx_dst   = {2'd0, 2'd3};
    core_tx_data  = 16'h1234;
    cycle();
    core_tx_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == 15) chk("tp_starve_pre", 32'(starve), 32'd0);
      if (i == 16) chk("tp_starve_set", 32'(starve), 32'd1);
    end
    nbr_valid = 4'b0111;
    cycle();
    chk("tp_starve_clear", 32'(starve), 32'd0);

    // TX backpressure: fifth offer is refused until the router frees up.
    nbr_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      core_tx_valid = 1'b1;
      core_tx_dst   = 4'($urandom);
      core_tx_data  = 16'($urandom);
      cycle();
    end
    chk("tp_tx_full", 32'(core_tx_ready), 32'd0);
    core_tx_valid = 1'b0;
    nbr_valid     = 4'b0000;
    repeat (4) cycle();
    chk("tp_tx_ready_back", 32'(core_tx_ready), 32'd1);
    chk("tp_inj_count_6", 32'(inj_count), 32'd6);

    // Ejection ordering.
    srcs[0] = {2'd0, 2'd3};
    srcs[1] = {2'd1, 2'd1};
    srcs[2] = {2'd3, 2'd0};
    for (int i = 0; i < 3; i++) begin
      doutLocal = mk_flit(srcs[i], 16'hB000 + 16'(i));
      cycle();
    end
    doutLocal     = '0;
    core_rx_ready = 1'b1;
    repeat (3) cycle();
    chk("tp_ej_count_3", 32'(ej_count), 32'd3);

    // Overflow: fifth flit into a full FIFO is lost; a flit that meets a
    // draining core is kept.
    core_rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      doutLocal = mk_flit(4'($urandom), 16'($urandom));
      cycle();
    end
    chk("tp_overflow", 32'(eject_overflow), 32'd1);
    chk("tp_ej_count_7", 32'(ej_count), 32'd7);
    core_rx_ready = 1'b1;
    doutLocal     = mk_flit(4'hC, 16'hCAFE);
    cycle();
    chk("tp_ej_count_8", 32'(ej_count), 32'd8);
    doutLocal = '0;
    repeat (5) cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      core_tx_valid = 1'($urandom);
      core_tx_dst   = 4'($urandom);
      core_tx_data  = 16'($urandom);
      nbr_valid     = 4'($urandom);
      doutLocal     = ($urandom_range(0, 2) == 0) ? mk_flit(4'($urandom), 16'($urandom)) : '0;
      core_rx_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Async reset with both FIFOs partly occupied.
    idle_inputs();
    repeat (6) cycle();
    nbr_valid     = 4'b1111;
    core_tx_valid = 1'b1;
    core_tx_dst   = {2'd3, 2'd3};
    core_tx_data  = 16'h5555;
    doutLocal     = mk_flit(4'h6, 16'h6666);
    repeat (2) cycle();
    chk("tp_pre_reset_rx_valid", 32'(core_rx_valid), 32'd1);
    idle_inputs();
    nbr_valid = 4'b0000;
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) cycle();

    // Clean traffic after reset.
    for (int i = 0; i < 100; i++) begin
      core_tx_valid = 1'($urandom);
      core_tx_dst   = 4'($urandom);
      core_tx_data  = 16'($urandom);
      nbr_valid     = 4'($urandom);
      doutLocal     = ($urandom_range(0, 1) == 0) ? mk_flit(4'($urandom), 16'($urandom)) : '0;
      core_rx_ready = 1'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
